// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped write-through cache controller.
package cache_pkg;

    localparam int CNT_W       = 8;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_INDEX_W = 2;
    localparam int TAG_W_DEF   = DEF_ADDR_W - DEF_INDEX_W;
    localparam int LINES_DEF   = 1 << DEF_INDEX_W;

    typedef enum logic [2:0] {
        IDLE,
        TAG,
        FETCH,
        FILL,
        WRITE,
        RESP
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage for one-word cache lines: async read by index,
// synchronous write of a whole line, valid bits cleared by reset.
module cache_line_array
    import cache_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags  [LINES];
    logic [DATA_W-1:0] words [LINES];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // NOTE: tag/data storage is deliberately not reset; the valid bits alone decide a hit.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tags[wr_index]  <= wr_tag;
            words[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = words[rd_index];

endmodule

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, write-through, no-write-allocate cache controller in front of a
// synchronous single-port RAM, with saturating hit/miss statistics.
module cache_ctrl_dm
    import cache_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int RAM_LAT = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              hit,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int TW     = ADDR_W - INDEX_W;
    localparam int WAIT_W = $clog2(RAM_LAT + 1);

    state_t              state;
    logic [ADDR_W-1:0]   cur_addr;
    logic                cur_we;
    logic [DATA_W-1:0]   cur_wdata;
    logic [WAIT_W-1:0]   wait_cnt;

    logic [INDEX_W-1:0]  cur_index;
    logic [TW-1:0]       cur_tag;
    logic                line_valid;
    logic [TW-1:0]       line_tag;
    logic [DATA_W-1:0]   line_data;
    logic                tag_match;
    logic                line_wr;
    logic [DATA_W-1:0]   line_wdata;

    assign cur_index = cur_addr[INDEX_W-1:0];
    assign cur_tag   = cur_addr[ADDR_W-1:INDEX_W];
    assign tag_match = line_valid && (line_tag == cur_tag);

    // A fill always installs a line; a write only refreshes a line that already hit.
    assign line_wr    = (state == FILL) || ((state == WRITE) && hit);
    assign line_wdata = (state == FILL) ? ram_q : cur_wdata;

    cache_line_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TW),
        .DATA_W  (DATA_W)
    ) u_lines (
        .clock    (clock),
        .resetn   (resetn),
        .rd_index (cur_index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (line_wr),
        .wr_index (cur_index),
        .wr_tag   (cur_tag),
        .wr_data  (line_wdata)
    );

    // ram_wren is a pure decode of the state register, so no other cycle can write RAM.
    assign ready    = (state == IDLE);
    assign done     = (state == RESP);
    assign ram_wren = (state == WRITE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            cur_addr    <= '0;
            cur_we      <= 1'b0;
            cur_wdata   <= '0;
            wait_cnt    <= '0;
            rdata       <= '0;
            hit         <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        cur_addr  <= addr;
                        cur_we    <= we;
                        cur_wdata <= wdata;
                        state     <= TAG;
                    end
                end
                TAG: begin
                    if (cur_we) begin
                        hit         <= tag_match;
                        ram_address <= cur_addr;
                        ram_data    <= cur_wdata;
                        state       <= WRITE;
                    end else if (tag_match) begin
                        rdata <= line_data;
                        hit   <= 1'b1;
                        state <= RESP;
                    end else begin
                        hit         <= 1'b0;
                        ram_address <= cur_addr;
                        wait_cnt    <= WAIT_W'(RAM_LAT);
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    if (wait_cnt == WAIT_W'(1)) begin
                        state <= FILL;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                FILL: begin
                    rdata <= ram_q;
                    state <= RESP;
                end
                WRITE: begin
                    state <= RESP;
                end
                RESP: begin
                    if (hit) begin
                        hit_count <= sat_inc(hit_count);
                    end else begin
                        miss_count <= sat_inc(miss_count);
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl_dm.sv
// Self-checking bench for cache_ctrl_dm: vector table through a scoreboard queue,
// plus hand sequences for ignored requests, reset mid-fetch and counter saturation.
module tb_cache_ctrl_dm;

    logic       clock;
    logic       resetn;
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       ready;
    logic       done;
    logic [7:0] rdata;
    logic       hit;
    logic [7:0] ram_address;
    logic [7:0] ram_data;
    logic       ram_wren;
    logic [7:0] ram_q;
    logic [7:0] hit_count;
    logic [7:0] miss_count;

    cache_ctrl_dm #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .INDEX_W (2),
        .RAM_LAT (1)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .ready       (ready),
        .done        (done),
        .rdata       (rdata),
        .hit         (hit),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM model: registered address, combinational q (latency 1).
    logic [7:0] mem [256];
    logic [7:0] ram_addr_q;
    int         wren_count = 0;
    int         done_count = 0;

    always @(posedge clock) begin
        if (ram_wren) begin
            mem[ram_address] <= ram_data;
            wren_count       <= wren_count + 1;
        end
        if (done === 1'b1) done_count <= done_count + 1;
        ram_addr_q <= ram_address;
    end
    assign ram_q = mem[ram_addr_q];

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_hit;
        int         exp_lat;
    } vec_t;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       hit;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int k = 0;
        while (ready !== 1'b1 && k < 16) begin
            @(negedge clock);
            k++;
        end
        if (ready !== 1'b1) check({name, " ready timeout"}, 32'(ready), 32'd1);
    endtask

    // Issue one request at a negedge, then follow it to done and score it.
    task automatic run_req(input logic w, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] er, input logic eh, input int el,
                           input string name);
        exp_t e;
        exp_t got;
        int   lat;
        int   wc0;
        bit   seen;
        wait_ready(name);
        e.we = w; e.addr = a; e.wdata = d; e.rdata = er; e.hit = eh; e.lat = el;
        sb.push_back(e);
        wc0 = wren_count;
        req = 1'b1; we = w; addr = a; wdata = d;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 64) begin
            @(negedge clock);
            lat++;
            if (lat == 1) req = 1'b0;
            if (done === 1'b1) seen = 1'b1;
        end
        got = sb.pop_front();
        if (!seen) begin
            check({name, " done timeout"}, 32'(seen), 32'd1);
        end else begin
            check({name, " rdata"}, 32'(rdata), 32'(got.rdata));
            check({name, " hit"}, 32'(hit), 32'(got.hit));
            check({name, " latency"}, 32'(lat), 32'(got.lat));
            check({name, " ram writes"}, 32'(wren_count - wc0), got.we ? 32'd1 : 32'd0);
            if (got.we || !got.hit) check({name, " ram_address"}, 32'(ram_address), 32'(got.addr));
            if (got.we) check({name, " ram content"}, 32'(mem[got.addr]), 32'(got.wdata));
        end
    endtask

    vec_t vecs[13];

    function automatic vec_t mk(input logic w, input logic [7:0] a, input logic [7:0] d,
                                input logic [7:0] er, input logic eh, input int el);
        vec_t v;
        v.we = w; v.addr = a; v.wdata = d; v.exp_rdata = er; v.exp_hit = eh; v.exp_lat = el;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_hits;
        int exp_miss;
        int d0;
        int k;

        // RAM[i] = i ^ 2F, so RAM[05]=2A, RAM[06]=29, RAM[09]=26, RAM[00]=2F, RAM[FF]=D0.
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h2F;

        vecs[0]  = mk(1'b0, 8'h05, 8'h00, 8'h2A, 1'b0, 4);  // cold read miss
        vecs[1]  = mk(1'b0, 8'h05, 8'h00, 8'h2A, 1'b1, 2);  // repeat read hits
        vecs[2]  = mk(1'b1, 8'h05, 8'h77, 8'h2A, 1'b1, 3);  // write hit, rdata held
        vecs[3]  = mk(1'b0, 8'h05, 8'h00, 8'h77, 1'b1, 2);  // line updated by write
        vecs[4]  = mk(1'b1, 8'h06, 8'h11, 8'h77, 1'b0, 3);  // write miss, no allocate
        vecs[5]  = mk(1'b0, 8'h06, 8'h00, 8'h11, 1'b0, 4);  // read after write miss
        vecs[6]  = mk(1'b0, 8'h09, 8'h00, 8'h26, 1'b0, 4);  // alias of index 1
        vecs[7]  = mk(1'b0, 8'h05, 8'h00, 8'h77, 1'b0, 4);  // evicted, refetched
        vecs[8]  = mk(1'b0, 8'h06, 8'h00, 8'h11, 1'b1, 2);  // index 2 untouched
        vecs[9]  = mk(1'b0, 8'h00, 8'h00, 8'h2F, 1'b0, 4);  // lowest address
        vecs[10] = mk(1'b0, 8'hFF, 8'h00, 8'hD0, 1'b0, 4);  // highest address
        vecs[11] = mk(1'b0, 8'h00, 8'h00, 8'h2F, 1'b1, 2);
        vecs[12] = mk(1'b0, 8'hFF, 8'h00, 8'hD0, 1'b1, 2);

        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        check("reset ready", 32'(ready), 32'd1);
        check("reset done", 32'(done), 32'd0);
        check("reset hit", 32'(hit), 32'd0);
        check("reset rdata", 32'(rdata), 32'd0);
        check("reset ram_wren", 32'(ram_wren), 32'd0);
        check("reset ram_address", 32'(ram_address), 32'd0);
        check("reset ram_data", 32'(ram_data), 32'd0);
        check("reset hit_count", 32'(hit_count), 32'd0);
        check("reset miss_count", 32'(miss_count), 32'd0);

        exp_hits = 0;
        exp_miss = 0;
        for (int i = 0; i < 13; i++) begin
            run_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
                    vecs[i].exp_hit, vecs[i].exp_lat, $sformatf("vec%0d", i));
            if (vecs[i].exp_hit) exp_hits++;
            else exp_miss++;
        end
        @(negedge clock);
        check("table hit_count", 32'(hit_count), 32'(exp_hits));
        check("table miss_count", 32'(miss_count), 32'(exp_miss));

        // Request pulsed while busy must be ignored.
        wait_ready("busy");
        d0 = done_count;
        sb.push_back('{we: 1'b0, addr: 8'h09, wdata: 8'h00, rdata: 8'h26, hit: 1'b0, lat: 4});
        req = 1'b1; we = 1'b0; addr = 8'h09;
        @(negedge clock);
        req = 1'b0;
        @(negedge clock);
        req = 1'b1; addr = 8'h00;
        @(negedge clock);
        req = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 32) begin
            @(negedge clock);
            k++;
        end
        begin
            exp_t got;
            got = sb.pop_front();
            check("busy done seen", 32'(done), 32'd1);
            check("busy rdata", 32'(rdata), 32'(got.rdata));
            check("busy hit", 32'(hit), 32'(got.hit));
        end
        repeat (6) @(negedge clock);
        check("busy single done", 32'(done_count - d0), 32'd1);
        check("busy ready", 32'(ready), 32'd1);
        check("busy miss_count", 32'(miss_count), 32'(exp_miss + 1));
        check("busy hit_count", 32'(hit_count), 32'(exp_hits));

        // Reset while the miss is in FETCH: no done, everything back to zero.
        wait_ready("rst");
        d0 = done_count;
        req = 1'b1; we = 1'b0; addr = 8'h05;
        @(negedge clock);
        req = 1'b0;
        @(negedge clock);
        check("rst fetch ram_address", 32'(ram_address), 32'h05);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        repeat (8) @(negedge clock);
        check("rst no done", 32'(done_count - d0), 32'd0);
        check("rst ready", 32'(ready), 32'd1);
        check("rst hit_count", 32'(hit_count), 32'd0);
        check("rst miss_count", 32'(miss_count), 32'd0);
        check("rst rdata", 32'(rdata), 32'd0);
        check("rst hit", 32'(hit), 32'd0);

        run_req(1'b0, 8'h05, 8'h00, 8'h77, 1'b0, 4, "post-rst 05");
        run_req(1'b0, 8'h00, 8'h00, 8'h2F, 1'b0, 4, "post-rst 00");

        // Saturation: 300 hits must pin hit_count at 255.
        for (int i = 0; i < 300; i++) begin
            run_req(1'b0, 8'h05, 8'h00, 8'h77, 1'b1, 2, "sat");
        end
        @(negedge clock);
        check("sat hit_count", 32'(hit_count), 32'd255);
        check("sat miss_count", 32'(miss_count), 32'd2);
        check("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
